// File: rtl/pe_inject_queue.sv
// pe_inject_queue: injection-side buffer between a PE and its 3D Hoplite router.
// Flits from the PE are queued in a small FIFO. The head flit is offered to the router
// for one cycle, and the block then waits one cycle for the router's registered
// injection_success. A refused flit is offered again, so flits leave in the order
// they arrived.
//
// state | meaning
// IDLE  | FIFO empty, nothing offered to the router
// ISSUE | head flit on pe_input with pe_in_valid=1 (exactly one cycle)
// WAIT  | injection_success reports the flit offered in ISSUE; pop on success
module pe_inject_queue #(
  parameter int FLIT_SIZE = 128,
  parameter int DEPTH     = 8,
  parameter int PTR_W     = 3,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_valid,
  input  logic [FLIT_SIZE-1:0] src_flit,
  output logic                 src_ready,
  output logic                 pe_in_valid,
  output logic [FLIT_SIZE-1:0] pe_input,
  input  logic                 injection_success,
  output logic [PTR_W:0]       occupancy,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic [CNT_W-1:0]     inject_count,
  output logic [CNT_W-1:0]     retry_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  state_t               state;
  logic [FLIT_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     head_addr;
  logic [PTR_W:0]       count;
  logic [PTR_W:0]       count_next;
  logic [FLIT_SIZE-1:0] head_next;
  logic                 wr_en;
  logic                 pop;

  assign src_ready  = (count != DEPTH_C);
  assign wr_en      = src_valid && src_ready;
  assign pop        = (state == WAIT) && injection_success;
  assign count_next = count + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, pop};

  assign occupancy  = count;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);

  // The flit to offer next cycle sits at rd_ptr, or at rd_ptr+1 if the head pops now.
  // If that slot is being written this very cycle, the memory does not hold it yet,
  // so the incoming flit is forwarded straight into the output register.
  always_comb begin
    head_addr = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    head_next = mem[head_addr];
    if (wr_en && (wr_ptr == head_addr)) begin
      head_next = src_flit;
    end
  end

  // Storage array; not reset, since the pointer reset discards its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= src_flit;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  // Offer sequencer: one ISSUE/WAIT round trip per attempt, with registered router outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pe_in_valid <= 1'b0;
      pe_input    <= '0;
    end else begin
      pe_in_valid <= 1'b0;
      pe_input    <= '0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state       <= ISSUE;
            pe_in_valid <= 1'b1;
            pe_input    <= head_next;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // A refusal re-offers the same head; a success moves to the next flit if one exists.
          if (!injection_success || (count_next != '0)) begin
            state       <= ISSUE;
            pe_in_valid <= 1'b1;
            pe_input    <= head_next;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Statistics: accepted flits and refused attempts, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      inject_count <= '0;
      retry_count  <= '0;
    end else if (state == WAIT) begin
      if (injection_success) begin
        inject_count <= inject_count + CNT_W'(1);
      end else begin
        retry_count <= retry_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_inject_queue.sv
// Bench for pe_inject_queue: a router model answers every offer, and a scoreboard
// checks that each offered flit is the oldest one accepted and not yet injected.
module tb_pe_inject_queue;
  localparam int F     = 128;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             src_valid;
  logic [F-1:0]     src_flit;
  logic             src_ready;
  logic             pe_in_valid;
  logic [F-1:0]     pe_input;
  logic             injection_success;
  logic [PTR_W:0]   occupancy;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] inject_count;
  logic [CNT_W-1:0] retry_count;

  always #5 clk = ~clk;

  pe_inject_queue #(
    .FLIT_SIZE(F),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_valid(src_valid),
    .src_flit(src_flit),
    .src_ready(src_ready),
    .pe_in_valid(pe_in_valid),
    .pe_input(pe_input),
    .injection_success(injection_success),
    .occupancy(occupancy),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .inject_count(inject_count),
    .retry_count(retry_count)
  );

  int               total = 0;
  int               bad = 0;
  logic [F-1:0]     exp_q[$];
  bit               succ_q[$];
  bit               hold_fail = 0;
  bit               rand_succ = 0;
  bit               force_succ = 0;
  bit               was_issue = 0;
  logic [CNT_W-1:0] exp_inj = '0;
  logic [CNT_W-1:0] exp_retry = '0;
  logic             s_valid = 1'b0;
  logic             s_wrote = 1'b0;
  logic [PTR_W:0]   s_occ = '0;
  logic [F-1:0]     s_last = '0;
  int               n_issue = 0;

  // One clock cycle: drive inputs and the router answer, sample at negedge, check the offer.
  task automatic tick(input logic v, input logic [F-1:0] f);
    bit succ;
    src_valid = v;
    src_flit  = f;
    succ = force_succ;
    if (was_issue) begin
      if (succ_q.size() != 0) succ = succ_q.pop_front();
      else if (rand_succ) succ = 1'($urandom_range(0, 1));
      else succ = !hold_fail;
      if (succ) begin
        exp_inj = exp_inj + 1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        exp_retry = exp_retry + 1;
      end
    end
    injection_success = succ;
    @(negedge clk);
    s_valid = pe_in_valid;
    s_occ   = occupancy;
    s_wrote = v && src_ready && !rst;
    total++;
    if (pe_in_valid) begin
      n_issue++;
      s_last = pe_input;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL order: offered %h with nothing pending", pe_input);
      end else if (pe_input !== exp_q[0]) begin
        bad++;
        $display("FAIL order: got %h want %h", pe_input, exp_q[0]);
      end
    end else if (pe_input !== '0) begin
      bad++;
      $display("FAIL idle_zero: pe_input=%h want 0", pe_input);
    end
    if (s_wrote) exp_q.push_back(f);
    was_issue = pe_in_valid;
    if (rst) begin
      exp_q.delete();
      succ_q.delete();
      was_issue = 0;
      exp_inj   = '0;
      exp_retry = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || was_issue) && k < budget) begin
      tick(1'b0, '0);
      k++;
    end
    total++;
    if (exp_q.size() != 0 || was_issue) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d after %0d cycles", exp_q.size(), k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, '0);
    tick(1'b0, '0);
    rst = 1'b0;
    total++;
    if ({pe_in_valid, src_ready, fifo_empty, fifo_full} !== 4'b0110) begin
      bad++;
      $display("FAIL reset_flags: valid/ready/empty/full=%b want 0110",
               {pe_in_valid, src_ready, fifo_empty, fifo_full});
    end
    total++;
    if (pe_input !== '0 || occupancy !== '0) begin
      bad++;
      $display("FAIL reset_data: pe_input=%h occupancy=%0d want 0 0", pe_input, occupancy);
    end
    total++;
    if (inject_count !== '0 || retry_count !== '0) begin
      bad++;
      $display("FAIL reset_counts: inject=%0d retry=%0d want 0 0", inject_count, retry_count);
    end
  endtask

  task automatic test_single();
    n_issue = 0;
    tick(1'b1, F'('hA5));
    for (int c = 1; c <= 6; c++) begin
      tick(1'b0, '0);
      total++;
      if (s_valid !== (c == 2)) begin
        bad++;
        $display("FAIL single_valid: cycle %0d pe_in_valid=%b want %b", c, s_valid, (c == 2));
      end
      total++;
      if (s_occ !== ((c >= 4) ? 3'd0 : 3'd1)) begin
        bad++;
        $display("FAIL single_occ: cycle %0d occupancy=%0d want %0d", c, s_occ, (c >= 4) ? 0 : 1);
      end
    end
    total++;
    if (n_issue != 1 || s_last !== F'('hA5)) begin
      bad++;
      $display("FAIL single_issue: offers=%0d last=%h want 1 a5", n_issue, s_last);
    end
    total++;
    if (inject_count !== exp_inj || retry_count !== exp_retry) begin
      bad++;
      $display("FAIL single_counts: inject=%0d retry=%0d want %0d %0d",
               inject_count, retry_count, exp_inj, exp_retry);
    end
  endtask

  task automatic test_retry();
    n_issue = 0;
    succ_q.push_back(1'b0);
    succ_q.push_back(1'b0);
    succ_q.push_back(1'b1);
    tick(1'b1, F'('h11));
    drain(40);
    total++;
    if (n_issue != 3 || s_last !== F'('h11)) begin
      bad++;
      $display("FAIL retry_offers: offers=%0d last=%h want 3 11", n_issue, s_last);
    end
    total++;
    if (inject_count !== exp_inj || retry_count !== exp_retry) begin
      bad++;
      $display("FAIL retry_counts: inject=%0d retry=%0d want %0d %0d",
               inject_count, retry_count, exp_inj, exp_retry);
    end
  endtask

  task automatic test_full();
    int k = 0;
    hold_fail = 1;
    for (int i = 1; i <= 4; i++) tick(1'b1, F'(i));
    total++;
    if (src_ready !== 1'b0 || fifo_full !== 1'b1 || occupancy !== 3'd4) begin
      bad++;
      $display("FAIL full_flags: ready=%b full=%b occupancy=%0d want 0 1 4",
               src_ready, fifo_full, occupancy);
    end
    tick(1'b1, F'(5));
    tick(1'b1, F'(5));
    total++;
    if (s_wrote !== 1'b0 || occupancy !== 3'd4) begin
      bad++;
      $display("FAIL full_hold: accepted=%b occupancy=%0d want 0 4", s_wrote, occupancy);
    end
    hold_fail = 0;
    s_wrote = 1'b0;
    while (!s_wrote && k < 20) begin
      tick(1'b1, F'(5));
      k++;
    end
    src_valid = 1'b0;
    total++;
    if (!s_wrote) begin
      bad++;
      $display("FAIL full_accept: flit 5 accepted=%b want 1", s_wrote);
    end
    drain(60);
    total++;
    if (s_last !== F'(5) || occupancy !== '0) begin
      bad++;
      $display("FAIL full_last: last=%h occupancy=%0d want 5 0", s_last, occupancy);
    end
  endtask

  task automatic test_simultaneous();
    int k = 0;
    tick(1'b1, F'('h21));
    tick(1'b1, F'('h22));
    while (!s_valid && k < 10) begin
      tick(1'b0, '0);
      k++;
    end
    total++;
    if (occupancy !== 3'd2) begin
      bad++;
      $display("FAIL simul_pre: occupancy=%0d want 2", occupancy);
    end
    tick(1'b1, F'('h77));
    total++;
    if (occupancy !== 3'd2) begin
      bad++;
      $display("FAIL simul_occ: occupancy=%0d want 2", occupancy);
    end
    drain(40);
    total++;
    if (s_last !== F'('h77) || occupancy !== '0) begin
      bad++;
      $display("FAIL simul_last: last=%h occupancy=%0d want 77 0", s_last, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    rand_succ = 1;
    for (int i = 0; i < 150; i++) begin
      tick(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
    end
    rand_succ = 0;
    drain(100);
    total++;
    if (inject_count !== exp_inj || retry_count !== exp_retry || occupancy !== '0) begin
      bad++;
      $display("FAIL b2b_counts: inject=%0d retry=%0d occ=%0d want %0d %0d 0",
               inject_count, retry_count, occupancy, exp_inj, exp_retry);
    end
  endtask

  task automatic test_reset_wait();
    int k = 0;
    hold_fail = 1;
    tick(1'b1, F'('h31));
    tick(1'b1, F'('h32));
    tick(1'b1, F'('h33));
    while (!s_valid && k < 10) begin
      tick(1'b0, '0);
      k++;
    end
    succ_q.push_back(1'b1);
    rst = 1'b1;
    tick(1'b1, F'('h99));
    rst = 1'b0;
    hold_fail = 0;
    force_succ = 1;
    n_issue = 0;
    for (int i = 0; i < 6; i++) tick(1'b0, '0);
    force_succ = 0;
    total++;
    if (n_issue != 0 || occupancy !== '0 || fifo_empty !== 1'b1) begin
      bad++;
      $display("FAIL rstwait_idle: offers=%0d occupancy=%0d empty=%b want 0 0 1",
               n_issue, occupancy, fifo_empty);
    end
    total++;
    if (inject_count !== exp_inj || retry_count !== exp_retry) begin
      bad++;
      $display("FAIL rstwait_counts: inject=%0d retry=%0d want %0d %0d",
               inject_count, retry_count, exp_inj, exp_retry);
    end
    tick(1'b1, F'('h44));
    drain(40);
    total++;
    if (s_last !== F'('h44) || inject_count !== exp_inj) begin
      bad++;
      $display("FAIL rstwait_after: last=%h inject=%0d want 44 %0d", s_last, inject_count, exp_inj);
    end
  endtask

  initial begin
    rst = 1'b1;
    src_valid = 1'b0;
    src_flit = '0;
    injection_success = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_retry();
    test_full();
    test_simultaneous();
    test_back_to_back();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
